// File: rtl/ghash_pkg.sv
// Shared GHASH definitions: field width, reduction constant, FSM state
// encodings and the single-bit GF(2^128) multiply step.
package ghash_pkg;

  localparam int GF_W = 128;

  // Reduction constant: x^128 = 1 + x + x^2 + x^7, in GCM bit order (bit127 = x^0).
  localparam logic [127:0] GF_R = {8'hE1, 120'h0};

  localparam logic [1:0] ST_IDLE = 2'd0;  // no key loaded
  localparam logic [1:0] ST_WAIT = 2'd1;  // key held, waiting for a block
  localparam logic [1:0] ST_MUL  = 2'd2;  // multiplier iterating
  localparam logic [1:0] ST_DONE = 2'd3;  // tag presented

  typedef struct packed {
    logic [127:0] z;
    logic [127:0] v;
  } gf_pair_t;

  // One shift-and-add step: conditionally fold V into Z, then multiply V by x.
  function automatic gf_pair_t gf_step(input logic [127:0] z,
                                       input logic [127:0] v,
                                       input logic         b);
    gf_pair_t r;
    if (b) begin
      r.z = z ^ v;
    end else begin
      r.z = z;
    end
    if (v[0]) begin
      r.v = (v >> 1) ^ GF_R;
    end else begin
      r.v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ghash_ctrl_mul.sv
// Combinational slice of the iterative GF(2^128) multiplier: applies
// MUL_BITS consecutive shift-and-add steps, most significant A bit first.
module gf128_mul_iter
  import ghash_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic [127:0]         z,
  input  logic [127:0]         v,
  input  logic [MUL_BITS-1:0]  a_bits,
  output logic [127:0]         z_next,
  output logic [127:0]         v_next
);

  // Chain MUL_BITS steps; a_bits[MUL_BITS-1] is the lowest-degree coefficient of this slice.
  always_comb begin
    gf_pair_t acc;
    acc.z = z;
    acc.v = v;
    for (int j = 0; j < MUL_BITS; j++) begin
      acc = gf_step(acc.z, acc.v, a_bits[MUL_BITS-1-j]);
    end
    z_next = acc.z;
    v_next = acc.v;
  end

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: holds H, accumulates Y_i = (Y_{i-1} ^ X_i) * H with an
// iterative multiplier, and presents the final Y as the tag on a
// valid/ready port.
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         h_valid,
  input  logic [127:0] h_key,
  output logic         h_ready,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_tag,
  input  logic         out_ready,
  output logic         busy
);

  localparam int         STEPS    = GF_W / MUL_BITS;
  localparam logic [7:0] LAST_CNT = 8'(STEPS - 1);

  if ((MUL_BITS < 1) || (MUL_BITS > GF_W) || ((GF_W % MUL_BITS) != 0)) begin : g_bad_mul_bits
    $error("ghash_ctrl: MUL_BITS must divide 128 (1,2,4,...,128)");
  end

  logic [1:0]   state;
  logic         key_ok;
  logic         msg_open;
  logic         last_q;
  logic [7:0]   cnt;
  logic [127:0] h;
  logic [127:0] y;
  logic [127:0] a;
  logic [127:0] z;
  logic [127:0] v;
  logic [127:0] z_next;
  logic [127:0] v_next;

  gf128_mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
    .z      (z),
    .v      (v),
    .a_bits (a[GF_W-1 -: MUL_BITS]),
    .z_next (z_next),
    .v_next (v_next)
  );

  // Handshake readies are a state decode, forced low while clear is asserted
  // so an abort never coincides with an accepted transfer.
  assign h_ready  = !clear && ((state == ST_IDLE) || ((state == ST_WAIT) && !msg_open));
  assign in_ready = !clear && (state == ST_WAIT);
  assign busy     = (state == ST_MUL) || (state == ST_DONE);

  // Main sequencer: key load, block intake, multiply iterations, tag hand-off and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_ok    <= 1'b0;
      msg_open  <= 1'b0;
      last_q    <= 1'b0;
      cnt       <= 8'd0;
      h         <= 128'h0;
      y         <= 128'h0;
      a         <= 128'h0;
      z         <= 128'h0;
      v         <= 128'h0;
      out_valid <= 1'b0;
      out_tag   <= 128'h0;
    end else if (clear) begin
      // Abort the message but keep the key; without a key there is nowhere to go but IDLE.
      if (key_ok) begin
        state <= ST_WAIT;
      end else begin
        state <= ST_IDLE;
      end
      y         <= 128'h0;
      msg_open  <= 1'b0;
      last_q    <= 1'b0;
      cnt       <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (h_valid) begin
            h      <= h_key;
            key_ok <= 1'b1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (h_valid && !msg_open) begin
            h <= h_key;
          end
          if (in_valid) begin
            z        <= 128'h0;
            v        <= h;
            a        <= y ^ in_data;
            last_q   <= in_last;
            msg_open <= 1'b1;
            cnt      <= 8'd0;
            state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          z   <= z_next;
          v   <= v_next;
          a   <= a << MUL_BITS;
          cnt <= cnt + 8'd1;
          if (cnt == LAST_CNT) begin
            y <= z_next;
            if (last_q) begin
              out_tag   <= z_next;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            y         <= 128'h0;
            msg_open  <= 1'b0;
            last_q    <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        default: begin
          state     <= ST_IDLE;
          key_ok    <= 1'b0;
          msg_open  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
